// File: rtl/ddr_ctr_rd_check.sv
// ddr_ctr_rd_check
//
// Purpose:
//   Read-data checker placed downstream of a DDR-controller read-request
//   generator. Every AR handshake is snooped into a small command FIFO. Every
//   accepted R beat is checked against the head command:
//     - the data must equal the beat address, replicated across the data width;
//     - rresp must be OKAY;
//     - rlast must be set exactly on the final beat.
//   Errors are kept as sticky flags, with a saturating event counter and a
//   capture of the first failure.
//
// Handshake semantics:
//   - A command is taken when arvalid & arready are both high on a rising edge.
//     This block only observes the AR channel; it never stalls it.
//   - A beat is taken when rvalid & rready are both high on a rising edge.
//     rready is a registered output of this block.
//
// Ports:
//   clk, rstn         : clock, synchronous active-low reset
//   araddr/arlen      : snooped AR address / burst length (beats-1)
//   arvalid/arready   : snooped AR handshake
//   rdata/rresp/rlast : R channel payload
//   rvalid/rready     : R channel handshake (rready driven here)
//   busy              : command FIFO holds at least one command
//   err, err_flags    : sticky error summary and per-type flags
//                       [0] data, [1] rresp, [2] rlast, [3] unexpected beat,
//                       [4] command overflow
//   err_cnt           : error cycles, saturating
//   burst_cnt         : completed bursts, saturating
//   beat_cnt          : accepted beats, wrapping
//   first_err_addr    : address captured at the first error
//   first_err_data    : data captured at the first error
//
// Optional feature:
//   RD_CHECK_THROTTLE_EN. When defined, an 8-bit LFSR gates rready to apply
//   roughly 25% backpressure.

module ddr_ctr_rd_check #(
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              err,
  output logic [4:0]        err_flags,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic [31:0]       beat_cnt,
  output logic [31:0]       first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int BYTES = DATA_W / 8;
  localparam int REP   = DATA_W / 32;

  // Command FIFO storage. The contents need no reset: the pointers define validity.
  logic [31:0]    fifo_addr_q [CMD_DEPTH];
  logic [7:0]     fifo_len_q  [CMD_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count;

  logic [7:0]        beat_idx_q, beat_idx_d;
  logic              rready_q, rready_d;
  logic [4:0]        err_flags_q, err_flags_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic [31:0]       first_addr_q, first_addr_d;
  logic [DATA_W-1:0] first_data_q, first_data_d;

`ifdef RD_CHECK_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;
`endif

  logic              fifo_empty, fifo_full;
  logic [31:0]       head_addr;
  logic [7:0]        head_len;
  logic [31:0]       beat_addr;
  logic [DATA_W-1:0] exp_data;
  logic              beat_acc, beat_chk, beat_unexp, at_end;
  logic              pop, ar_hs, push;
  logic [4:0]        new_flags;
  logic              beat_err;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(CMD_DEPTH));
  assign head_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
  assign head_len   = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
  assign beat_addr  = head_addr + (32'(beat_idx_q) * 32'(BYTES));
  assign exp_data   = {REP{beat_addr}};

  always_comb begin
    beat_acc   = rvalid & rready_q;
    beat_chk   = beat_acc & ~fifo_empty;
    // A push in the same cycle is not yet visible, so the beat is unexpected.
    beat_unexp = beat_acc & fifo_empty;
    at_end     = (beat_idx_q == head_len);
    // The burst ends at head_len or at an early rlast, whichever comes first.
    pop        = beat_chk & (at_end | rlast);
    ar_hs      = arvalid & arready;
    // A full FIFO still accepts a push if the head leaves in the same cycle.
    push       = ar_hs & (~fifo_full | pop);

    new_flags[0] = beat_chk & (rdata != exp_data);
    new_flags[1] = beat_chk & (rresp != 2'b00);
    new_flags[2] = beat_chk & (rlast != at_end);
    new_flags[3] = beat_unexp;
    new_flags[4] = ar_hs & ~push;
    beat_err     = |new_flags[2:0];

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    beat_idx_d  = beat_idx_q;
    if (pop)           beat_idx_d = '0;
    else if (beat_chk) beat_idx_d = beat_idx_q + 8'd1;

    err_flags_d = err_flags_q | new_flags;
    err_cnt_d   = err_cnt_q;
    if ((|new_flags) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    burst_cnt_d = burst_cnt_q;
    if (pop && (burst_cnt_q != '1)) burst_cnt_d = burst_cnt_q + 1'b1;
    beat_cnt_d  = beat_acc ? beat_cnt_q + 32'd1 : beat_cnt_q;

    // The capture is armed while no flag has been seen yet. Beat errors take
    // priority over an unexpected beat, which takes priority over an overflow.
    first_addr_d = first_addr_q;
    first_data_d = first_data_q;
    if ((|new_flags) && (err_flags_q == 5'b0)) begin
      if (beat_err) begin
        first_addr_d = beat_addr;
        first_data_d = rdata;
      end else if (beat_unexp) begin
        first_addr_d = 32'h0;
        first_data_d = rdata;
      end else begin
        first_addr_d = araddr;
        first_data_d = '0;
      end
    end

`ifdef RD_CHECK_THROTTLE_EN
    // Fibonacci LFSR with taps 8,6,5,4. rready follows the next LFSR state,
    // so the registered rready always matches the current LFSR value.
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rready_d = (lfsr_d[1:0] != 2'b00);
`else
    rready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_idx_q   <= '0;
      rready_q     <= 1'b0;
      err_flags_q  <= '0;
      err_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
`ifdef RD_CHECK_THROTTLE_EN
      lfsr_q       <= 8'hA5;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_idx_q   <= beat_idx_d;
      rready_q     <= rready_d;
      err_flags_q  <= err_flags_d;
      err_cnt_q    <= err_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      first_addr_q <= first_addr_d;
      first_data_q <= first_data_d;
`ifdef RD_CHECK_THROTTLE_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= araddr;
      fifo_len_q[wr_ptr_q[PTR_W-1:0]]  <= arlen;
    end
  end

  assign rready         = rready_q;
  assign busy           = ~fifo_empty;
  assign err            = |err_flags_q;
  assign err_flags      = err_flags_q;
  assign err_cnt        = err_cnt_q;
  assign burst_cnt      = burst_cnt_q;
  assign beat_cnt       = beat_cnt_q;
  assign first_err_addr = first_addr_q;
  assign first_err_data = first_data_q;

endmodule

// File: tb/tb_ddr_ctr_rd_check.sv
// Testbench for ddr_ctr_rd_check: directed scenarios followed by random traffic,
// checked against a queue-based reference model through an expected-value queue.
module tb_ddr_ctr_rd_check;

  localparam int DATA_W    = 32;
  localparam int CMD_DEPTH = 4;
  localparam int CNT_W     = 16;
  localparam int BYTES     = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       araddr = '0;
  logic [7:0]        arlen = '0;
  logic              arvalid = 1'b0, arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0, rvalid = 1'b0;
  logic              rready, busy, err;
  logic [4:0]        err_flags;
  logic [CNT_W-1:0]  err_cnt, burst_cnt;
  logic [31:0]       beat_cnt, first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  ddr_ctr_rd_check #(.DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy), .err(err), .err_flags(err_flags), .err_cnt(err_cnt),
    .burst_cnt(burst_cnt), .beat_cnt(beat_cnt), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]        flags;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [31:0]       beat_cnt;
    logic              busy;
    logic [31:0]       fa;
    logic [DATA_W-1:0] fd;
  } snap_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  snap_t exp_q[$];
  cmd_t  m_cmd[$];
  int    m_idx;
  snap_t m;

  int total = 0;
  int bad   = 0;

  function automatic logic [DATA_W-1:0] rep(input logic [31:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = a;
    return r;
  endfunction

  function automatic logic [31:0] head_beat_addr();
    return m_cmd[0].addr + 32'(m_idx) * 32'(BYTES);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle's events (beat first, then command) to the model and
  // queue the status expected after that cycle.
  task automatic model_step(input bit ar, input bit beat);
    logic [4:0]        nf;
    logic [31:0]       fa, a;
    logic [DATA_W-1:0] fd;
    bit                last_exp;
    nf = '0;
    fa = '0;
    fd = '0;
    if (beat) begin
      m.beat_cnt++;
      if (m_cmd.size() == 0) begin
        nf[3] = 1'b1;
        fa = 32'h0;
        fd = rdata;
      end else begin
        a = head_beat_addr();
        last_exp = (m_idx == int'(m_cmd[0].len));
        nf[0] = (rdata != rep(a));
        nf[1] = (rresp != 2'b00);
        nf[2] = (rlast != last_exp);
        if (nf[2:0] != 0) begin
          fa = a;
          fd = rdata;
        end
        if (last_exp || rlast) begin
          void'(m_cmd.pop_front());
          m_idx = 0;
          if (m.burst_cnt != '1) m.burst_cnt++;
        end else begin
          m_idx++;
        end
      end
    end
    if (ar) begin
      if (m_cmd.size() < CMD_DEPTH) begin
        m_cmd.push_back('{addr: araddr, len: arlen});
      end else begin
        nf[4] = 1'b1;
        if (nf[3:0] == 0) begin
          fa = araddr;
          fd = '0;
        end
      end
    end
    if (nf != 0) begin
      if (m.flags == 0) begin
        m.fa = fa;
        m.fd = fd;
      end
      m.flags |= nf;
      if (m.err_cnt != '1) m.err_cnt++;
    end
    m.busy = (m_cmd.size() != 0);
    exp_q.push_back(m);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the beat (if any) is taken.
  task automatic step(input bit ar_v, input logic [31:0] a, input logic [7:0] l,
                      input bit r_v, input logic [DATA_W-1:0] d,
                      input logic [1:0] resp, input bit last);
    bit ar_left;
    bit acc;
    int tries;
    ar_left = ar_v;
    tries = 0;
    arvalid = ar_v; arready = ar_v; araddr = a; arlen = l;
    rvalid = r_v; rdata = d; rresp = resp; rlast = last;
    while (1) begin
      @(negedge clk);
      acc = r_v && rready;
      if (ar_left || acc) model_step(ar_left, acc);
      ar_left = 0;
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      arready = 1'b0;
      if (!r_v || acc) break;
      tries++;
      if (tries > 50) begin
        total++;
        bad++;
        $display("FAIL rready_timeout: got rready=0 for 50 cycles expected 1");
        break;
      end
    end
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic [1:0] resp, input bit last);
    step(0, 32'h0, 8'h0, 1, d, resp, last);
  endtask

  task automatic ar(input logic [31:0] a, input logic [7:0] l);
    step(1, a, l, 0, '0, 2'b00, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    arvalid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    m_cmd.delete();
    m_idx = 0;
    m = '0;
    @(negedge clk);
    chk("rst_rready", rready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", err_flags, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_first_addr", first_err_addr, 0);
    chk("rst_first_data", first_err_data, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
`ifndef RD_CHECK_THROTTLE_EN
    chk("rready_after_rst", rready, 1);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit pend = 0;
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL no_expect: got an event expected none");
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        chk("sb_flags", err_flags, e.flags);
        chk("sb_err", err, |e.flags);
        chk("sb_err_cnt", err_cnt, e.err_cnt);
        chk("sb_burst_cnt", burst_cnt, e.burst_cnt);
        chk("sb_beat_cnt", beat_cnt, e.beat_cnt);
        chk("sb_busy", busy, e.busy);
        chk("sb_first_addr", first_err_addr, e.fa);
        chk("sb_first_data", first_err_data, e.fd);
      end
    end
    pend = rstn && ((arvalid && arready) || (rvalid && rready));
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] d;
    logic [1:0]        rs;
    bit                lst, do_ar, do_beat;
    logic [31:0]       ra;
    int                wait_cyc;

    m = '0;
    m_idx = 0;
    do_reset();

    // 1: single beat
    ar(32'h0, 8'd0);
    beat(rep(32'h0), 2'b00, 1);
    chk("t1_burst_cnt", burst_cnt, 1);
    chk("t1_busy", busy, 0);

    // 2: clean 4-beat burst
    do_reset();
    ar(32'h100, 8'd3);
    for (int i = 0; i < 4; i++) beat(rep(32'h100 + 32'(i * 4)), 2'b00, i == 3);
    chk("t2_burst_cnt", burst_cnt, 1);
    chk("t2_flags", err_flags, 0);

    // 3: corrupt third beat
    do_reset();
    ar(32'h100, 8'd3);
    for (int i = 0; i < 4; i++)
      beat((i == 2) ? DATA_W'(32'hDEAD) : rep(32'h100 + 32'(i * 4)), 2'b00, i == 3);
    chk("t3_flags", err_flags, 5'b00001);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_first_addr", first_err_addr, 32'h108);
    chk("t3_first_data", first_err_data, 32'hDEAD);

    // 4: early rlast, then bad rresp
    do_reset();
    ar(32'h200, 8'd3);
    beat(rep(32'h200), 2'b00, 0);
    beat(rep(32'h204), 2'b00, 1);
    chk("t4_flags_last", err_flags, 5'b00100);
    chk("t4_burst_cnt", burst_cnt, 1);
    ar(32'h300, 8'd0);
    beat(rep(32'h300), 2'b10, 1);
    chk("t4_flags_resp", err_flags, 5'b00110);

    // 5: overflow, drain, then an unexpected beat
    do_reset();
    for (int i = 0; i < 5; i++) ar(32'h400 + 32'(i * 16), 8'd0);
    chk("t5_flags_ovf", err_flags, 5'b10000);
    chk("t5_busy", busy, 1);
    chk("t5_first_addr", first_err_addr, 32'h440);
    for (int i = 0; i < 4; i++) beat(rep(32'h400 + 32'(i * 16)), 2'b00, 1);
    chk("t5_busy_drained", busy, 0);
    beat(rep(32'h12345678), 2'b00, 1);
    chk("t5_flags_unexp", err_flags, 5'b11000);

    // 6: reset mid-burst, then a clean burst
    do_reset();
    ar(32'h500, 8'd3);
    beat(rep(32'h500), 2'b00, 0);
    beat(rep(32'h504), 2'b00, 0);
    do_reset();
    ar(32'h600, 8'd0);
    beat(rep(32'h600), 2'b00, 1);
    chk("t6_err", err, 0);
    chk("t6_burst_cnt", burst_cnt, 1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      do_ar = ($urandom_range(0, 2) == 0);
      do_beat = (m_cmd.size() > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      ra = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) * 4);
      if (m_cmd.size() > 0) begin
        d   = rep(head_beat_addr());
        lst = (m_idx == int'(m_cmd[0].len));
      end else begin
        d   = DATA_W'($urandom);
        lst = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) d = d ^ DATA_W'($urandom_range(1, 255));
      rs = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 15) == 0) lst = ~lst;
      if (do_ar || do_beat)
        step(do_ar, ra, 8'($urandom_range(0, 3)), do_beat, d, rs, lst);
      else begin
        @(posedge clk);
        #1;
      end
    end

    // Let the monitor consume the last expectation.
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("exp_q_drained", 128'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_ctr_rd_check.md
Name: ddr_ctr_rd_check

Overview:
- Read-data checker that sits directly downstream of the DDR-controller read-request stimulus.
- Snoops every AR handshake (araddr/arlen) into a small command FIFO.
- Consumes the DDR controller's R channel and checks each beat against an address-derived pattern, burst length/rlast alignment and rresp.
- Reports sticky error flags, counters and first-failure capture for bring-up on the LoongArch processing system.

Parameters:
- DATA_W, 32: R-channel data width; must be a multiple of 32.
- CMD_DEPTH, 4: AR-command FIFO depth; must be a power of two and at least 2.
- CNT_W, 16: width of the error and burst counters.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- araddr  in  32  snooped AR address
- arlen  in  8  snooped AR burst length (beats-1)
- arvalid  in  1  snooped AR valid
- arready  in  1  snooped AR ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  last beat of burst
- rvalid  in  1  read data valid
- rready  out  1  read data ready (driven by this block)
- busy  out  1  command FIFO non-empty
- err  out  1  sticky OR of err_flags
- err_flags  out  5  sticky flags: [0] data mismatch, [1] rresp!=0, [2] rlast mismatch, [3] unexpected beat, [4] command overflow
- err_cnt  out  CNT_W  total error events, saturating
- burst_cnt  out  CNT_W  completed bursts, saturating
- beat_cnt  out  32  accepted beats, wraps
- first_err_addr  out  32  beat address of first error
- first_err_data  out  DATA_W  rdata of first error

Behaviour:
- Reset (rstn=0 at posedge clk): every output is 0, including rready. The FIFO is emptied and the beat index is cleared. Reset mid-burst discards the burst silently with no error.
- rready: driven to 1 from the first clock after rstn=1 and held there. It is a registered output.
- Command push: arvalid&arready pushes {araddr, arlen}.
  - If the FIFO is full after accounting for a same-cycle pop, the command is dropped. err_flags[4] is set and err_cnt is incremented.
- Beat acceptance: rvalid&rready.
- Beat address: head_addr + beat_idx*(DATA_W/8), using 32-bit wrap-around arithmetic.
- Expected data: the beat address replicated DATA_W/32 times.
- Per accepted beat with the FIFO non-empty:
  - data != expected sets flag [0].
  - rresp != 0 sets flag [1].
  - rlast != (beat_idx==head_len) sets flag [2].
- Burst end: on (beat_idx==head_len) or rlast, whichever comes first:
  - the head is popped;
  - beat_idx returns to 0;
  - burst_cnt is incremented.
- Otherwise beat_idx increments. An early rlast therefore terminates the burst, and a missing rlast still pops at head_len.
- Accepted beat with the FIFO empty sets flag [3]. The beat is not compared and nothing is popped.
  - A push in the same cycle is not visible until the next cycle, so this case still counts as an unexpected beat.
- Error counting: err_cnt increments by 1 per cycle in which any error condition occurs. A cycle with multiple conditions still counts once, and err_cnt saturates at all-ones.
- First-error capture: first_err_addr/data are captured on the first error event only.
  - For an unexpected beat, addr=0.
  - For an overflow-only event, addr=the dropped araddr and data=0.
- beat_cnt increments on every accepted beat.
- Latency: all status outputs update on the clock edge that accepts the beat or command. They are visible the following cycle.
- busy: 1 whenever the FIFO holds at least one command.
- Error clearing: flags clear only on reset.

Optional Feature:
- Macro: RD_CHECK_THROTTLE_EN.
- When defined:
  - an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4, advancing every cycle after reset) gates rready;
  - rready=1 when LFSR[1:0]!=2'b00, giving about 25% backpressure;
  - checking is unchanged.
- When undefined: rready is held constantly at 1 after reset as above, and the LFSR logic is absent.

Test Plan:
1. Single beat: AR araddr=0x0, arlen=0; R rdata=0x00000000, rlast=1, rresp=0 -> burst_cnt=1, beat_cnt=1, err=0, busy returns to 0.
2. 4-beat burst: araddr=0x100, arlen=3; rdata=0x100, 0x104, 0x108, 0x10C with rlast on the 4th beat -> burst_cnt=1, err_flags=0.
3. Corrupt beat: same as scenario 2 but the 3rd beat is 0xDEAD -> err_flags[0]=1, err_cnt=1, first_err_addr=0x108, first_err_data=0xDEAD.
4. Length and response errors:
   - rlast on beat 2 of an arlen=3 burst -> flag [2] set, head popped, burst_cnt=1.
   - Next burst with rresp=2'b10 -> flag [1] set.
5. FIFO limits: 5 AR handshakes back-to-back with no R traffic (CMD_DEPTH=4) -> flag [4] set, busy=1.
   - Then an R beat after the FIFO drains -> flag [3] set.
6. Reset mid-burst: rstn=0 after 2 of 4 beats -> all outputs 0.
   - A fresh arlen=0 burst afterwards passes with err=0.
